tx_msg_scheduler: RTL
=====================

Name: tx_msg_scheduler

Overview:
Sequencer and arbiter for the UART status-message byte source. Three requesters post message requests: start-control, initial and normal. The block grants one request at a time by fixed priority, selects the message and steps the 6-bit byte index 0..MSG_LEN-1. It handshakes each byte with the UART transmitter and inserts an idle gap between messages. It replaces the free-running counter stepping, driving the message ROM select and index from one clock domain.

Parameters:
MSG_LEN, 35, bytes per message; last index is MSG_LEN-1; must be ≤64.
GAP_CYCLES, 16, idle clk cycles after a message before the next grant; 0 means no gap state.
TIMEOUT_CYCLES, 4096, max clk cycles in WAIT for iTX_DONE before abort.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
iREQ_START  in  1  start-control message request, 1-cycle pulse
iREQ_INIT  in  1  initial message request, 1-cycle pulse
iREQ_NORM  in  1  normal message request, 1-cycle pulse
iFINISH  in  1  synchronous abort; level, sampled on clk
iTX_DONE  in  1  UART byte complete, 1-cycle pulse
oSEL  out  2  message select: 00 none, 01 INIT, 10 NORM, 11 START
oBYTE_IDX  out  6  current byte index into the message ROM
oTX_START  out  1  1-cycle pulse: UART loads the ROM byte
oBUSY  out  1  high in any state other than IDLE
oMSG_DONE  out  1  1-cycle pulse on the final byte's iTX_DONE
oTIMEOUT  out  1  1-cycle pulse when the WAIT timeout fires

Behaviour:
- Reset (async, reset=0): state IDLE, all pending bits 0, oSEL=00, oBYTE_IDX=0, all pulse outputs 0, oBUSY=0, gap and timeout counters 0.
- Pending flags: each iREQ_x pulse sets pend_x on that edge. A flag is cleared only by its own grant or by iFINISH. Repeated pulses while a flag is set are merged.
- A request for the class currently being sent sets its pending flag again, so the message is re-sent after the gap.
- Priority at grant: START > INIT > NORM. No fairness.
- States: IDLE, LOAD, SEND, WAIT, GAP.
  - IDLE: if any pend bit is set, grant the highest; set oSEL, clear that pend bit, set oBYTE_IDX=0, go to LOAD. A request pulsed at edge N is granted at edge N+1 at the earliest.
  - LOAD: one cycle for the registered ROM output; go to SEND.
  - SEND: oTX_START=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: on iTX_DONE:
    - if oBYTE_IDX==MSG_LEN-1: pulse oMSG_DONE, go to GAP (IDLE if GAP_CYCLES=0).
    - else: oBYTE_IDX+1, go to LOAD.
    - iTX_DONE outside WAIT is ignored.
  - GAP: count GAP_CYCLES cycles, then go to IDLE with oSEL=00 and oBYTE_IDX=0. oSEL holds the last grant during GAP.
- Byte cadence: minimum 3 cycles per byte plus UART time. oTX_START pulses are never back-to-back.
- Timeout: the WAIT counter reaching TIMEOUT_CYCLES-1 without iTX_DONE pulses oTIMEOUT, suppresses oMSG_DONE and goes to GAP. The message is dropped, not retried.
- iFINISH=1, from any state, on the next edge:
  - state IDLE, oSEL=00, oBYTE_IDX=0, all pend cleared;
  - oTX_START, oMSG_DONE and oTIMEOUT forced 0;
  - requests arriving in the same cycle as iFINISH are dropped;
  - while iFINISH stays high, no grant and no pend set.
- Simultaneous iTX_DONE and iFINISH: iFINISH wins, no oMSG_DONE.
- oBYTE_IDX never exceeds MSG_LEN-1; there is no wrap within a message.
- Reset asserted mid-message: immediate async return to reset values; the UART is not waited on.

Test Plan:
- Single INIT: iREQ_INIT pulse, UART model returns iTX_DONE 10 cycles after each oTX_START → oSEL=01, exactly 35 oTX_START pulses with oBYTE_IDX 0..34 in order, one oMSG_DONE on the idx-34 done, 16 GAP cycles, then oBUSY=0 and oSEL=00.
- Arbitration: iREQ_NORM, iREQ_INIT and iREQ_START pulsed in the same cycle → messages sent in order oSEL 11, 01, 10; three oMSG_DONE pulses, each separated by ≥16 idle cycles.
- Re-request: iREQ_START pulsed while START is at idx 20 → the START message completes, the gap runs, then START repeats from idx 0; a second pulse in the same message causes no third send.
- Abort: iFINISH high for 1 cycle at WAIT with idx 10 and pend_NORM set → next edge IDLE, oSEL=00, oBYTE_IDX=0, no oMSG_DONE, NORM never sent; a later iTX_DONE is ignored.
- Timeout: TIMEOUT_CYCLES=64, UART never responds after idx 3 → oTIMEOUT pulses exactly 64 cycles after that oTX_START, no oMSG_DONE, GAP then IDLE.
- Reset: reset low during SEND → all outputs at reset values asynchronously, before the next clk edge; after release with no requests, oBUSY stays 0.

Source files
------------

// File: rtl/tx_msg_scheduler.sv
// ---------------------------------------------------------------------------
// tx_msg_scheduler
//
// Sequencer and arbiter for the UART status-message byte source. Three
// requesters (start-control, initial, normal) post 1-cycle request pulses
// that are latched as pending flags. One request is granted at a time by
// fixed priority START > INIT > NORM. For the granted message the block
// steps the byte index 0..MSG_LEN-1, handshakes each byte with the UART
// (oTX_START out, iTX_DONE back) and inserts an idle gap between messages.
//
// Per-byte sequence: LOAD (ROM output settles) -> SEND (oTX_START pulse)
// -> WAIT (for iTX_DONE, bounded by TIMEOUT_CYCLES).
//
// Parameters:
//   MSG_LEN         bytes per message, 1..64
//   GAP_CYCLES      idle cycles between messages, 0 = no gap state
//   TIMEOUT_CYCLES  WAIT budget in cycles after oTX_START, must be >= 2
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   iREQ_START  start-control message request pulse
//   iREQ_INIT   initial message request pulse
//   iREQ_NORM   normal message request pulse
//   iFINISH     synchronous abort (level)
//   iTX_DONE    UART byte-complete pulse
//   oSEL        message select: 00 none, 01 INIT, 10 NORM, 11 START
//   oBYTE_IDX   current byte index into the message ROM
//   oTX_START   1-cycle pulse, UART loads the ROM byte
//   oBUSY       high whenever the sequencer is not idle
//   oMSG_DONE   1-cycle pulse after the final byte completes
//   oTIMEOUT    1-cycle pulse when a byte handshake times out
// All outputs are registered.
// ---------------------------------------------------------------------------
module tx_msg_scheduler #(
    parameter int MSG_LEN        = 35,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iREQ_START,
    input  logic       iREQ_INIT,
    input  logic       iREQ_NORM,
    input  logic       iFINISH,
    input  logic       iTX_DONE,
    output logic [1:0] oSEL,
    output logic [5:0] oBYTE_IDX,
    output logic       oTX_START,
    output logic       oBUSY,
    output logic       oMSG_DONE,
    output logic       oTIMEOUT
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_INIT  = 2'b01;
    localparam logic [1:0] SEL_NORM  = 2'b10;
    localparam logic [1:0] SEL_START = 2'b11;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [5:0]       LAST_IDX = 6'(MSG_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    // The counter is cleared in SEND and steps once per WAIT cycle. The abort
    // fires on the WAIT cycle whose increment would make the counter reach
    // TIMEOUT_CYCLES-1, which places oTIMEOUT exactly TIMEOUT_CYCLES cycles
    // after the oTX_START pulse of the unanswered byte.
    localparam logic [TO_W-1:0]  TO_FIRE  = TO_W'(TIMEOUT_CYCLES - 2);
    localparam bit               NO_GAP   = (GAP_CYCLES == 0);

    // Registered state
    logic [2:0]       state_r;
    logic [1:0]       sel_r;
    logic [5:0]       idx_r;
    logic             pendStart_r;
    logic             pendInit_r;
    logic             pendNorm_r;
    logic [GAP_W-1:0] gapCnt_r;
    logic [TO_W-1:0]  toCnt_r;
    logic             txStart_r;
    logic             busy_r;
    logic             msgDone_r;
    logic             timeout_r;

    // Next-state values
    logic [2:0]       stateNext_s;
    logic [1:0]       selNext_s;
    logic [5:0]       idxNext_s;
    logic             pendStartNext_s;
    logic             pendInitNext_s;
    logic             pendNormNext_s;
    logic [GAP_W-1:0] gapCntNext_s;
    logic [TO_W-1:0]  toCntNext_s;
    logic             msgDoneNext_s;
    logic             timeoutNext_s;
    logic             msgEnd_s;

    // Next-state, grant and pending-flag logic
    always_comb begin
        stateNext_s     = state_r;
        selNext_s       = sel_r;
        idxNext_s       = idx_r;
        pendStartNext_s = pendStart_r | iREQ_START;
        pendInitNext_s  = pendInit_r  | iREQ_INIT;
        pendNormNext_s  = pendNorm_r  | iREQ_NORM;
        gapCntNext_s    = gapCnt_r;
        toCntNext_s     = toCnt_r;
        msgDoneNext_s   = 1'b0;
        timeoutNext_s   = 1'b0;
        msgEnd_s        = 1'b0;

        if (iFINISH) begin
            // Abort wins over everything, including same-cycle requests
            // and a same-cycle final iTX_DONE.
            stateNext_s     = ST_IDLE;
            selNext_s       = SEL_NONE;
            idxNext_s       = 6'd0;
            pendStartNext_s = 1'b0;
            pendInitNext_s  = 1'b0;
            pendNormNext_s  = 1'b0;
            gapCntNext_s    = '0;
            toCntNext_s     = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Grant from registered flags; a pulse arriving in the
                    // grant cycle stays pending for a later repeat.
                    if (pendStart_r) begin
                        selNext_s       = SEL_START;
                        pendStartNext_s = iREQ_START;
                        idxNext_s       = 6'd0;
                        stateNext_s     = ST_LOAD;
                    end else if (pendInit_r) begin
                        selNext_s       = SEL_INIT;
                        pendInitNext_s  = iREQ_INIT;
                        idxNext_s       = 6'd0;
                        stateNext_s     = ST_LOAD;
                    end else if (pendNorm_r) begin
                        selNext_s       = SEL_NORM;
                        pendNormNext_s  = iREQ_NORM;
                        idxNext_s       = 6'd0;
                        stateNext_s     = ST_LOAD;
                    end else begin
                        stateNext_s     = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    stateNext_s = ST_SEND;
                end
                ST_SEND: begin
                    toCntNext_s = '0;
                    stateNext_s = ST_WAIT;
                end
                ST_WAIT: begin
                    if (iTX_DONE) begin
                        if (idx_r == LAST_IDX) begin
                            msgDoneNext_s = 1'b1;
                            msgEnd_s      = 1'b1;
                        end else begin
                            idxNext_s   = idx_r + 6'd1;
                            stateNext_s = ST_LOAD;
                        end
                    end else if (toCnt_r == TO_FIRE) begin
                        // Drop the message; no retry and no oMSG_DONE.
                        timeoutNext_s = 1'b1;
                        msgEnd_s      = 1'b1;
                    end else begin
                        toCntNext_s = toCnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_GAP: begin
                    // oSEL keeps the last grant until the gap expires.
                    if (gapCnt_r == GAP_LAST) begin
                        stateNext_s = ST_IDLE;
                        selNext_s   = SEL_NONE;
                        idxNext_s   = 6'd0;
                    end else begin
                        gapCntNext_s = gapCnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    stateNext_s = ST_IDLE;
                    selNext_s   = SEL_NONE;
                    idxNext_s   = 6'd0;
                end
            endcase

            // Common exit after a completed or timed-out message.
            if (msgEnd_s) begin
                if (NO_GAP) begin
                    stateNext_s = ST_IDLE;
                    selNext_s   = SEL_NONE;
                    idxNext_s   = 6'd0;
                end else begin
                    stateNext_s  = ST_GAP;
                    gapCntNext_s = '0;
                end
            end else begin
                stateNext_s = stateNext_s;
            end
        end
    end

    // State, counter and registered-output update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            sel_r       <= SEL_NONE;
            idx_r       <= 6'd0;
            pendStart_r <= 1'b0;
            pendInit_r  <= 1'b0;
            pendNorm_r  <= 1'b0;
            gapCnt_r    <= '0;
            toCnt_r     <= '0;
            txStart_r   <= 1'b0;
            busy_r      <= 1'b0;
            msgDone_r   <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            sel_r       <= selNext_s;
            idx_r       <= idxNext_s;
            pendStart_r <= pendStartNext_s;
            pendInit_r  <= pendInitNext_s;
            pendNorm_r  <= pendNormNext_s;
            gapCnt_r    <= gapCntNext_s;
            toCnt_r     <= toCntNext_s;
            txStart_r   <= (stateNext_s == ST_SEND);
            busy_r      <= (stateNext_s != ST_IDLE);
            msgDone_r   <= msgDoneNext_s;
            timeout_r   <= timeoutNext_s;
        end
    end

    assign oSEL      = sel_r;
    assign oBYTE_IDX = idx_r;
    assign oTX_START = txStart_r;
    assign oBUSY     = busy_r;
    assign oMSG_DONE = msgDone_r;
    assign oTIMEOUT  = timeout_r;

endmodule
